img_stream_writer: RTL and testbench

//  Parametrised stream-to-SRAM image loader: accepts pixels on a valid/ready stream and writes

---
 rtl/img_rx_pkg.sv | 9 +
 rtl/img_rx_addr_gen.sv | 77 +++++++
 rtl/img_stream_writer.sv | 103 ++++++++++
 tb/tb_img_stream_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_rx_pkg.sv
// Shared types and default widths for the image stream loader, SRAM and conv blocks.
package img_rx_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int IDX_W_DEFAULT  = 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} img_rx_state_t;

endpackage

// File: rtl/img_rx_addr_gen.sv
// Row/col index counter for the image loader; latches the last indices on load.
// IMG_RX_COLMAJOR_EN adds a col_major input selecting column-first ordering.
module img_rx_addr_gen
  import img_rx_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             step,
  input  logic [IDX_W-1:0] nrows,
  input  logic [IDX_W-1:0] ncols,
`ifdef IMG_RX_COLMAJOR_EN
  input  logic             col_major,
`endif
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [IDX_W-1:0] nrows_q;
  logic [IDX_W-1:0] ncols_q;
  logic             row_end;
  logic             col_end;
  logic             row_major;

`ifdef IMG_RX_COLMAJOR_EN
  logic col_major_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     col_major_q <= 1'b0;
    else if (load) col_major_q <= col_major;
  end

  assign row_major = ~col_major_q;
`else
  assign row_major = 1'b1;
`endif

  assign row_end = (row == nrows_q);
  assign col_end = (col == ncols_q);
  assign last    = row_end & col_end;

  // Equality against the latched last index: the counter never reaches the
  // natural wrap point, so a full 2**IDX_W frame needs no extra bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nrows_q <= '0;
      ncols_q <= '0;
      row     <= '0;
      col     <= '0;
    end else if (load) begin
      nrows_q <= nrows;
      ncols_q <= ncols;
      row     <= '0;
      col     <= '0;
    end else if (step) begin
      if (row_major) begin
        if (col_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        if (row_end) begin
          row <= '0;
          col <= col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/img_stream_writer.sv
// Stream-to-SRAM image loader: FSM, one-deep write stage and status flags.
// IMG_RX_COLMAJOR_EN adds a col_major port (sampled on accepted start).
module img_stream_writer
  import img_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  nrows,
  input  logic [IDX_W-1:0]  ncols,
`ifdef IMG_RX_COLMAJOR_EN
  input  logic              col_major,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              err_drop,
  output logic              sram_sense_en,
  output logic              sram_write_en,
  output logic [IDX_W-1:0]  sram_row,
  output logic [IDX_W-1:0]  sram_col,
  output logic [DATA_W-1:0] sram_din
);

  img_rx_state_t    state;
  img_rx_state_t    state_next;
  logic             handshake;
  logic             accept;
  logic             last;
  logic [IDX_W-1:0] idx_row;
  logic [IDX_W-1:0] idx_col;

  assign in_ready      = (state == RUN);
  assign handshake     = in_valid & in_ready;
  assign busy          = (state != IDLE) | sram_write_en;
  assign accept        = start & ~abort & ~busy;
  assign frame_done    = (state == FLUSH) & ~abort;
  assign sram_sense_en = 1'b1;

  img_rx_addr_gen #(.IDX_W(IDX_W)) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .load      (accept),
    .step      (handshake),
    .nrows     (nrows),
    .ncols     (ncols),
`ifdef IMG_RX_COLMAJOR_EN
    .col_major (col_major),
`endif
    .row       (idx_row),
    .col       (idx_col),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = RUN;
        RUN:     if (handshake && last) state_next = FLUSH;
        FLUSH:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A pixel accepted in the same cycle as abort is still written out whole.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_write_en <= 1'b0;
      sram_row      <= '0;
      sram_col      <= '0;
      sram_din      <= '0;
    end else begin
      sram_write_en <= handshake;
      if (handshake) begin
        sram_row <= idx_row;
        sram_col <= idx_col;
        sram_din <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          err_drop <= 1'b0;
    else if (accept)                    err_drop <= 1'b0;
    else if (in_valid && state != RUN)  err_drop <= 1'b1;
  end

endmodule

// File: tb/tb_img_stream_writer.sv
// Directed self-checking bench for img_stream_writer; the column-major
// sequence runs only when IMG_RX_COLMAJOR_EN is defined.
module tb_img_stream_writer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic       col_major;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       frame_done;
  logic       err_drop;
  logic       sram_sense_en;
  logic       sram_write_en;
  logic [7:0] sram_row;
  logic [7:0] sram_col;
  logic [7:0] sram_din;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  img_stream_writer #(.DATA_W(8), .IDX_W(8)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .abort         (abort),
    .nrows         (nrows),
    .ncols         (ncols),
`ifdef IMG_RX_COLMAJOR_EN
    .col_major     (col_major),
`endif
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_drop      (err_drop),
    .sram_sense_en (sram_sense_en),
    .sram_write_en (sram_write_en),
    .sram_row      (sram_row),
    .sram_col      (sram_col),
    .sram_din      (sram_din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [7:0] d);
    start    = s;
    abort    = a;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
    checkOutput({tag, "_we"},  32'(sram_write_en), 32'd1);
    checkOutput({tag, "_row"}, 32'(sram_row), 32'(r));
    checkOutput({tag, "_col"}, 32'(sram_col), 32'(c));
    checkOutput({tag, "_din"}, 32'(sram_din), 32'(d));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_we"},   32'(sram_write_en), 32'd0);
    checkOutput({tag, "_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_rdy"},  32'(in_ready), 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    nrows     = 8'd0;
    ncols     = 8'd0;
    col_major = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    $display("[TB] reset state");
    checkIdle("rst");
    checkOutput("rst_err",   32'(err_drop), 32'd0);
    checkOutput("rst_sense", 32'(sram_sense_en), 32'd1);
    checkOutput("rst_row",   32'(sram_row), 32'd0);
    checkOutput("rst_din",   32'(sram_din), 32'd0);
    #11 rstn = 1'b1;

    $display("[TB] 2x3 frame, back-to-back");
    nrows = 8'd1; ncols = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_rdy",  32'(in_ready), 32'd1);
    checkOutput("t1_we0",  32'(sram_write_en), 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
      tick();
      checkWrite("t1_wr", 8'(i / 3), 8'(i % 3), 8'(8'h10 + i));
      checkOutput("t1_done", 32'(frame_done), (i == 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkIdle("t1_end");
    checkOutput("t1_err", 32'(err_drop), 32'd0);

    $display("[TB] 2x3 frame, gapped valid");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
      tick();
      checkWrite("t2_wr", 8'(i / 3), 8'(i % 3), 8'(8'h40 + i));
      checkOutput("t2_done", 32'(frame_done), (i == 5) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      if (i < 5) begin
        checkOutput("t2_gap_we",   32'(sram_write_en), 32'd0);
        checkOutput("t2_gap_row",  32'(sram_row), 32'(i / 3));
        checkOutput("t2_gap_col",  32'(sram_col), 32'(i % 3));
        checkOutput("t2_gap_busy", 32'(busy), 32'd1);
      end else begin
        checkIdle("t2_end");
      end
    end

    $display("[TB] 1x1 frame, start during FLUSH");
    nrows = 8'd0; ncols = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hAB);
    tick();
    checkWrite("t3_wr", 8'd0, 8'd0, 8'hAB);
    checkOutput("t3_done", 32'(frame_done), 32'd1);
    nrows = 8'd5;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    checkIdle("t3_end");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkIdle("t3_still");
    checkOutput("t3_err", 32'(err_drop), 32'd0);

    $display("[TB] abort after 3 pixels");
    nrows = 8'd1; ncols = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i == 2), 1'b1, 8'(8'h20 + i));
      tick();
      checkWrite("t4_wr", 8'd0, 8'(i), 8'(8'h20 + i));
      checkOutput("t4_done", 32'(frame_done), 32'd0);
    end
    checkOutput("t4_rdy",  32'(in_ready), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkIdle("t4_idle");
    nrows = 8'd0; ncols = 8'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
      tick();
      checkWrite("t4_new", 8'd0, 8'(i), 8'(8'h30 + i));
      checkOutput("t4_new_done", 32'(frame_done), (i == 1) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkIdle("t4_end");

    $display("[TB] drop error while idle");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
    tick();
    checkOutput("t5_we",  32'(sram_write_en), 32'd0);
    checkOutput("t5_err", 32'(err_drop), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("t5_sticky", 32'(err_drop), 32'd1);
    nrows = 8'd0; ncols = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("t5_clr", 32'(err_drop), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55);
    tick();
    checkWrite("t5_wr", 8'd0, 8'd0, 8'h55);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    $display("[TB] async reset mid-frame");
    nrows = 8'd1; ncols = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h9C);
    tick();
    checkWrite("t6_wr", 8'd0, 8'd0, 8'h9C);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rstn = 1'b0;
    #1;
    checkIdle("t6_rst");
    checkOutput("t6_rst_din", 32'(sram_din), 32'd0);
    #1 rstn = 1'b1;
    tick();
    checkIdle("t6_after");

`ifdef IMG_RX_COLMAJOR_EN
    $display("[TB] column-major 2x3 frame");
    nrows = 8'd1; ncols = 8'd2; col_major = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    col_major = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h60 + i));
      tick();
      checkWrite("t7_wr", 8'(i % 2), 8'(i / 2), 8'(8'h60 + i));
      checkOutput("t7_done", 32'(frame_done), (i == 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkIdle("t7_end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
